blake2_seq: RTL and testbench

//  On-chip sequencer for the BLAKE2s hash core's byte-wide bus (8b data + 3b ctrl in, ready/hash_v + 8b hash out).

---
 rtl/blake2_seq_pkg.sv | 24 ++
 rtl/blake2_seq_wdog.sv | 28 ++
 rtl/blake2_seq.sv | 210 +++++++++++++++++++++
 tb/tb_blake2_seq.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2_seq_pkg.sv
// Shared definitions for the BLAKE2s bus sequencer.
//   state_t      : sequencer FSM states
//   cmd_t        : core_ctrl_o command codes (low two bits of the ctrl bus)
//   BLOCK_B_DFLT : default block size in bytes for BLAKE2s
package blake2_seq_pkg;

  localparam int BLOCK_B_DFLT = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_WAIT_RDY,
    S_BLK,
    S_HASH
  } state_t;

  typedef enum logic [1:0] {
    CMD_CFG   = 2'b00,
    CMD_DATA  = 2'b01,
    CMD_LAST  = 2'b10,  // last byte of a non-final block
    CMD_FINAL = 2'b11   // last byte of the final block
  } cmd_t;

endpackage

// File: rtl/blake2_seq_wdog.sv
// Watchdog counter for the BLAKE2s sequencer (built only with BLAKE2_SEQ_TIMEOUT_EN).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   run        : sequencer is in a state that can stall on the core
//   kick       : forward progress this cycle; restarts the count
//   expired    : count saturated while still waiting with no progress
module blake2_seq_wdog #(
  parameter int TO_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic kick,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  // Leaving the watched states clears the count, so every entry starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n)              cnt <= '0;
    else if (!run || kick)   cnt <= '0;
    else if (cnt != '1)      cnt <= cnt + TO_W'(1);
  end

  assign expired = run && !kick && (cnt == '1);

endmodule

// File: rtl/blake2_seq.sv
// BLAKE2s bus sequencer: turns a start command plus a key/message byte stream into
// config bytes and zero-padded 64-byte blocks for the hash core, then returns the digest.
// Optional watchdog: define BLAKE2_SEQ_TIMEOUT_EN to abort stalls in WAIT_RDY/HASH.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   start_i, cfg_kk/nn/ll_i    : start pulse and transfer config (sampled at start)
//   s_valid_i/s_data_i/s_ready_o : key-then-message byte stream
//   core_data_o, core_ctrl_o   : byte and {valid, cmd} to the core
//   core_ready_i               : core can take the next block
//   core_hash_v_i, core_hash_i : digest bytes from the core
//   h_valid_o/h_data_o/h_last_o : digest byte stream out (no backpressure)
//   busy_o, err_o              : transfer in progress, sticky watchdog error
module blake2_seq
  import blake2_seq_pkg::*;
#(
  parameter int BLOCK_B = BLOCK_B_DFLT,
  parameter int LL_B    = 4,
  parameter int TO_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [5:0]        cfg_kk_i,
  input  logic [5:0]        cfg_nn_i,
  input  logic [8*LL_B-1:0] cfg_ll_i,
  input  logic              s_valid_i,
  input  logic [7:0]        s_data_i,
  output logic              s_ready_o,
  output logic [7:0]        core_data_o,
  output logic [2:0]        core_ctrl_o,
  input  logic              core_ready_i,
  input  logic              core_hash_v_i,
  input  logic [7:0]        core_hash_i,
  output logic              h_valid_o,
  output logic [7:0]        h_data_o,
  output logic              h_last_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int LW = 8 * LL_B;
  localparam int IW = $clog2(BLOCK_B + LL_B + 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(BLOCK_B - 1);
  localparam logic [IW-1:0] CFG_LAST = IW'(LL_B + 1);

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;          // byte index in CFG and BLK
  logic [5:0]      key_rem, key_rem_n;  // key bytes still to send
  logic [LW-1:0]   msg_rem, msg_rem_n;  // message bytes still to send
  logic [5:0]      nn, nn_n;
  logic [5:0]      h_cnt, h_cnt_n;
  logic            key_blk, key_blk_n;  // current/next block carries the key
  logic            final_blk, final_n;
  logic            s_ready_n, hv_n, hl_n, busy_n;
  logic [7:0]      cdata_n, hd_n;
  logic [2:0]      cctrl_n;
  logic            seg_live, send, to_hit;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    key_rem_n = key_rem;
    msg_rem_n = msg_rem;
    nn_n      = nn;
    h_cnt_n   = h_cnt;
    key_blk_n = key_blk;
    final_n   = final_blk;
    cdata_n   = '0;
    cctrl_n   = '0;
    hv_n      = 1'b0;
    hd_n      = '0;
    hl_n      = 1'b0;
    seg_live  = key_blk ? (key_rem != '0) : (msg_rem != '0);
    send      = !seg_live || (s_valid_i && s_ready_o);

    case (state)
      S_IDLE: begin
        // busy_o stays high through the h_last_o cycle, which also blocks a restart there.
        if (start_i && !busy_o) begin
          state_n   = S_CFG;
          idx_n     = '0;
          key_rem_n = cfg_kk_i;
          nn_n      = cfg_nn_i;
          msg_rem_n = cfg_ll_i;
          key_blk_n = (cfg_kk_i != '0);
          h_cnt_n   = '0;
        end
      end
      S_CFG: begin
        cctrl_n = {1'b1, CMD_CFG};
        if (idx == '0)             cdata_n = {2'b00, key_rem};
        else if (idx == IW'(1))    cdata_n = {2'b00, nn};
        else                       cdata_n = 8'(msg_rem >> {idx - IW'(2), 3'b000});
        if (idx == CFG_LAST) begin
          state_n = S_WAIT_RDY;
          idx_n   = '0;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      S_WAIT_RDY: begin
        if (core_ready_i) begin
          state_n = S_BLK;
          idx_n   = '0;
          // The key block is final only with an empty message; a message block is
          // final once what is left fits in it (covers the kk=0, ll=0 empty block).
          final_n = key_blk ? (msg_rem == '0) : (msg_rem <= LW'(BLOCK_B));
        end
      end
      S_BLK: begin
        if (send) begin
          cdata_n = seg_live ? s_data_i : 8'h00;
          if (seg_live && key_blk)  key_rem_n = key_rem - 6'd1;
          if (seg_live && !key_blk) msg_rem_n = msg_rem - LW'(1);
          if (idx == IDX_LAST) begin
            cctrl_n   = {1'b1, final_blk ? CMD_FINAL : CMD_LAST};
            idx_n     = '0;
            key_blk_n = 1'b0;
            state_n   = final_blk ? S_HASH : S_WAIT_RDY;
          end else begin
            cctrl_n = {1'b1, CMD_DATA};
            idx_n   = idx + IW'(1);
          end
        end
      end
      S_HASH: begin
        if (core_hash_v_i) begin
          hv_n = 1'b1;
          hd_n = core_hash_i;
          if (h_cnt == nn - 6'd1) begin
            hl_n    = 1'b1;
            state_n = S_IDLE;
          end else begin
            h_cnt_n = h_cnt + 6'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (to_hit) state_n = S_IDLE;

    // Outputs are registered, so the stream handshake is decided from next-cycle state.
    s_ready_n = (state_n == S_BLK) && (key_blk_n ? (key_rem_n != '0) : (msg_rem_n != '0));
    busy_n    = (state_n != S_IDLE) || hl_n;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      key_rem     <= '0;
      msg_rem     <= '0;
      nn          <= '0;
      h_cnt       <= '0;
      key_blk     <= 1'b0;
      final_blk   <= 1'b0;
      s_ready_o   <= 1'b0;
      core_data_o <= '0;
      core_ctrl_o <= '0;
      h_valid_o   <= 1'b0;
      h_data_o    <= '0;
      h_last_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      key_rem     <= key_rem_n;
      msg_rem     <= msg_rem_n;
      nn          <= nn_n;
      h_cnt       <= h_cnt_n;
      key_blk     <= key_blk_n;
      final_blk   <= final_n;
      s_ready_o   <= s_ready_n;
      core_data_o <= cdata_n;
      core_ctrl_o <= cctrl_n;
      h_valid_o   <= hv_n;
      h_data_o    <= hd_n;
      h_last_o    <= hl_n;
      busy_o      <= busy_n;
    end
  end

`ifdef BLAKE2_SEQ_TIMEOUT_EN
  logic wd_run, wd_kick;

  assign wd_run  = (state == S_WAIT_RDY) || (state == S_HASH);
  assign wd_kick = ((state == S_WAIT_RDY) && core_ready_i) ||
                   ((state == S_HASH) && core_hash_v_i);

  blake2_seq_wdog #(.TO_W(TO_W)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (wd_run),
    .kick    (wd_kick),
    .expired (to_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)      err_o <= 1'b0;
    else if (to_hit) err_o <= 1'b1;
  end
`else
  assign to_hit = 1'b0;
  assign err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_blake2_seq.sv
// Self-checking bench for blake2_seq: a scoreboard of expected core/digest bytes is
// filled as each transfer is started and drained by a monitor sampling on negedge.
`timescale 1ns/1ps
module tb_blake2_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [5:0]  cfg_kk_i = '0;
  logic [5:0]  cfg_nn_i = '0;
  logic [31:0] cfg_ll_i = '0;
  logic        s_valid_i;
  logic [7:0]  s_data_i;
  logic        s_ready_o;
  logic [7:0]  core_data_o;
  logic [2:0]  core_ctrl_o;
  logic        core_ready_i = 1'b1;
  logic        core_hash_v_i = 1'b0;
  logic [7:0]  core_hash_i = '0;
  logic        h_valid_o;
  logic [7:0]  h_data_o;
  logic        h_last_o;
  logic        busy_o;
  logic        err_o;

  always #5 clk = ~clk;

  blake2_seq #(.BLOCK_B(64), .LL_B(4), .TO_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .cfg_kk_i      (cfg_kk_i),
    .cfg_nn_i      (cfg_nn_i),
    .cfg_ll_i      (cfg_ll_i),
    .s_valid_i     (s_valid_i),
    .s_data_i      (s_data_i),
    .s_ready_o     (s_ready_o),
    .core_data_o   (core_data_o),
    .core_ctrl_o   (core_ctrl_o),
    .core_ready_i  (core_ready_i),
    .core_hash_v_i (core_hash_v_i),
    .core_hash_i   (core_hash_i),
    .h_valid_o     (h_valid_o),
    .h_data_o      (h_data_o),
    .h_last_o      (h_last_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  int checks = 0;
  int errors = 0;

  logic [10:0] core_q[$];   // {ctrl, data}
  logic [8:0]  h_q[$];      // {last, data}
  logic [7:0]  stream_q[$];

  int accepted = 0;
  int gap_at = -1;
  int gap_len = 0;
  int gap_cnt = 0;
  int data_seen = 0;
  int blk_end = 0;
  int final_seen = 0;
  logic busy_at_last = 1'b0;
  logic busy_after_last = 1'b1;
  logic last_pend = 1'b0;
  int txn_abase;
  int txn_fbase;

  // Stream source: holds each byte until accepted, with an optional gap.
  initial begin : stream_drv
    logic take;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    forever begin
      @(negedge clk);
      take = s_valid_i && s_ready_o;
      @(posedge clk);
      #1;
      if (take && stream_q.size() > 0) begin
        void'(stream_q.pop_front());
        accepted++;
        if (accepted == gap_at) gap_cnt = gap_len;
      end
      if (gap_cnt > 0) begin
        s_valid_i = 1'b0;
        gap_cnt--;
      end else if (stream_q.size() > 0) begin
        s_valid_i = 1'b1;
        s_data_i  = stream_q[0];
      end else begin
        s_valid_i = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [10:0] ec;
    logic [8:0]  eh;
    if (last_pend) begin
      busy_after_last = busy_o;
      last_pend = 1'b0;
    end
    if (core_ctrl_o[2] === 1'b1) begin
      if (core_ctrl_o[1:0] != 2'b00) data_seen++;
      if (core_ctrl_o == 3'b110) blk_end++;
      if (core_ctrl_o == 3'b111) final_seen++;
      checks++;
      if (core_q.size() == 0) begin
        errors++;
        $display("FAIL core_extra got ctrl=%b data=%h, expected no byte", core_ctrl_o, core_data_o);
      end else begin
        ec = core_q.pop_front();
        if ({core_ctrl_o, core_data_o} !== ec)
          begin
            errors++;
            $display("FAIL core_byte got ctrl=%b data=%h, expected ctrl=%b data=%h",
                     core_ctrl_o, core_data_o, ec[10:8], ec[7:0]);
          end
      end
    end
    if (h_valid_o === 1'b1) begin
      checks++;
      if (h_q.size() == 0) begin
        errors++;
        $display("FAIL h_extra got last=%b data=%h, expected no byte", h_last_o, h_data_o);
      end else begin
        eh = h_q.pop_front();
        if ({h_last_o, h_data_o} !== eh) begin
          errors++;
          $display("FAIL h_byte got last=%b data=%h, expected last=%b data=%h",
                   h_last_o, h_data_o, eh[8], eh[7:0]);
        end
      end
      if (h_last_o) begin
        busy_at_last = busy_o;
        last_pend = 1'b1;
      end
    end
  end

  initial begin : global_timeout
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Pushes the expected core byte stream and starts a transfer.
  task automatic start_txn(input int kk, input int nn, input int ll, input int seed, input bit cfg_only);
    logic [7:0] key[$];
    logic [7:0] msg[$];
    logic [7:0] d;
    logic [2:0] c;
    int nmsg;
    for (int i = 0; i < kk; i++) key.push_back(8'(8'hA0 + i));
    for (int i = 0; i < ll; i++) msg.push_back(8'(seed + i));
    core_q.push_back({3'b100, 8'(kk)});
    core_q.push_back({3'b100, 8'(nn)});
    for (int b = 0; b < 4; b++) core_q.push_back({3'b100, 8'(ll >> (8 * b))});
    if (!cfg_only) begin
      nmsg = (ll + 63) / 64;
      if (kk == 0 && ll == 0) nmsg = 1;
      if (kk > 0) begin
        for (int i = 0; i < 64; i++) begin
          d = (i < kk) ? key[i] : 8'h00;
          c = (i == 63) ? ((ll == 0) ? 3'b111 : 3'b110) : 3'b101;
          core_q.push_back({c, d});
        end
      end
      for (int b = 0; b < nmsg; b++) begin
        for (int i = 0; i < 64; i++) begin
          d = (b * 64 + i < ll) ? msg[b * 64 + i] : 8'h00;
          c = (i == 63) ? ((b == nmsg - 1) ? 3'b111 : 3'b110) : 3'b101;
          core_q.push_back({c, d});
        end
      end
    end
    foreach (key[i]) stream_q.push_back(key[i]);
    foreach (msg[i]) stream_q.push_back(msg[i]);
    txn_abase = accepted;
    txn_fbase = final_seen;
    @(posedge clk);
    #1;
    cfg_kk_i = 6'(kk);
    cfg_nn_i = 6'(nn);
    cfg_ll_i = 32'(ll);
    start_i  = 1'b1;
    @(posedge clk);
    #1;
    start_i  = 1'b0;
  endtask

  // Waits for the final block, feeds digest bytes (two extra), checks drain and stream count.
  task automatic finish_txn(input int nn, input int exp_acc, input string name);
    int n;
    logic [7:0] hb;
    n = 0;
    while (final_seen <= txn_fbase && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (final_seen <= txn_fbase) begin
      errors++;
      $display("FAIL %s_final_timeout got no final block, expected one", name);
    end
    for (int i = 0; i < nn + 2; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        core_hash_v_i = 1'b0;
        @(posedge clk);
        #1;
      end
      hb = 8'(8'hC0 + i);
      core_hash_v_i = 1'b1;
      core_hash_i   = hb;
      if (i < nn) h_q.push_back({(i == nn - 1), hb});
    end
    @(posedge clk);
    #1;
    core_hash_v_i = 1'b0;
    n = 0;
    while (busy_o !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_end got busy=%b, expected 0", name, busy_o);
    end
    checks++;
    if (core_q.size() != 0 || h_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got core_left=%0d h_left=%0d, expected 0 0", name, core_q.size(), h_q.size());
    end
    checks++;
    if (accepted - txn_abase != exp_acc) begin
      errors++;
      $display("FAIL %s_accepted got %0d, expected %0d", name, accepted - txn_abase, exp_acc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_ready_o, core_data_o, core_ctrl_o, h_valid_o, h_data_o, h_last_o, busy_o, err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h, expected 0",
               {s_ready_o, core_data_o, core_ctrl_o, h_valid_o, h_data_o, h_last_o, busy_o, err_o});
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    start_txn(0, 32, 3, 8'h61, 1'b0);
    checks++;
    @(negedge clk);
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_start got %b, expected 1", busy_o);
    end
    finish_txn(32, 3, "basic");
  endtask

  task automatic test_empty();
    start_txn(0, 16, 0, 0, 1'b0);
    finish_txn(16, 0, "empty");
    checks++;
    if (busy_at_last !== 1'b1 || busy_after_last !== 1'b0) begin
      errors++;
      $display("FAIL empty_busy_fall got at_last=%b after=%b, expected 1 0", busy_at_last, busy_after_last);
    end
  endtask

  task automatic test_key_multi();
    start_txn(4, 32, 65, 8'h10, 1'b0);
    finish_txn(32, 69, "key_multi");
  endtask

  task automatic test_stall();
    int n;
    int db;
    int bb;
    db = data_seen;
    bb = blk_end;
    start_txn(8, 8, 70, 8'h40, 1'b0);
    gap_at  = txn_abase + 3;
    gap_len = 5;
    n = 0;
    while (data_seen <= db && n < 500) begin
      @(negedge clk);
      n++;
    end
    core_ready_i = 1'b0;
    n = 0;
    while (accepted < txn_abase + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (accepted < txn_abase + 3) begin
      errors++;
      $display("FAIL stall_gap_timeout got accepted=%0d, expected 3", accepted - txn_abase);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (core_ctrl_o[2] !== 1'b0) begin
        errors++;
        $display("FAIL stall_gap_valid got %b, expected 0", core_ctrl_o[2]);
      end
    end
    n = 0;
    while (blk_end <= bb && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (core_ctrl_o[2] !== 1'b0) begin
        errors++;
        $display("FAIL stall_rdy_valid got %b, expected 0", core_ctrl_o[2]);
      end
    end
    @(posedge clk);
    #1;
    core_ready_i = 1'b1;
    gap_at = -1;
    finish_txn(8, 78, "stall");
  endtask

  task automatic test_reset_abort();
    int n;
    int db;
    db = data_seen;
    start_txn(0, 4, 40, 8'h20, 1'b0);
    n = 0;
    while (data_seen < db + 20 && n < 500) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    core_q.delete();
    h_q.delete();
    stream_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_ready_o, core_data_o, core_ctrl_o, h_valid_o, h_data_o, h_last_o, busy_o, err_o} !== '0) begin
      errors++;
      $display("FAIL abort_outputs got %h, expected 0",
               {s_ready_o, core_data_o, core_ctrl_o, h_valid_o, h_data_o, h_last_o, busy_o, err_o});
    end
    repeat (2) @(negedge clk);
    start_txn(0, 32, 3, 8'h61, 1'b0);
    finish_txn(32, 3, "after_abort");
  endtask

  task automatic test_timeout();
    core_ready_i = 1'b0;
`ifdef BLAKE2_SEQ_TIMEOUT_EN
    start_txn(0, 4, 0, 0, 1'b1);
    repeat (21) @(posedge clk);
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got err=%b, expected 0", err_o);
    end
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire got err=%b busy=%b, expected 1 0", err_o, busy_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err_o !== 1'b1 || core_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_sticky got err=%b core_left=%0d, expected 1 0", err_o, core_q.size());
    end
    core_ready_i = 1'b1;
`else
    start_txn(0, 4, 0, 8'h00, 1'b0);
    repeat (40) @(negedge clk);
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b1 || core_q.size() != 64) begin
      errors++;
      $display("FAIL wait_forever got err=%b busy=%b core_left=%0d, expected 0 1 64",
               err_o, busy_o, core_q.size());
    end
    @(posedge clk);
    #1;
    core_ready_i = 1'b1;
    finish_txn(4, 0, "wait_forever");
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL wait_err got %b, expected 0", err_o);
    end
`endif
  endtask

  initial begin : main
    test_reset();
    test_basic();
    test_empty();
    test_key_multi();
    test_stall();
    test_reset_abort();
    test_timeout();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
